// File: rtl/sdram_arbiter_nch.sv
// N-reader / one-writer arbiter in front of the SDRAM Avalon bridge master.
// Writer beats readers; readers use round-robin or fixed priority, and a stuck bridge is aborted by a timeout.
module sdram_arbiter_nch #(
  parameter int NUM_RD  = 2,
  parameter int WADDR_W = 25,
  parameter int DATA_W  = 16,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic                        clk50,
  input  logic                        reset_n,
  input  logic                        write_override,
  input  logic [NUM_RD-1:0]           rd_en_mask,
  input  logic [NUM_RD-1:0]           rd_req,
  input  logic [NUM_RD*WADDR_W-1:0]   rd_addr,
  output logic [NUM_RD-1:0]           rd_ack,
  output logic [DATA_W-1:0]           rd_data,
  input  logic                        wr_req,
  input  logic [WADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_ack,
  output logic [WADDR_W:0]            addr_out_toavl,
  output logic                        read_out_toavl,
  output logic                        write_out_toavl,
  output logic [DATA_W-1:0]           wrdata_out_toavl,
  input  logic [DATA_W-1:0]           rddata_in_toavl,
  input  logic                        ack_in_toavl,
  output logic [NUM_RD:0]             grant,
  output logic                        timeout_err
);

  localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]         state_q,  state_d;
  logic [PTR_W-1:0]   ptr_q,    ptr_d;
  logic [PTR_W-1:0]   owner_q,  owner_d;
  logic               own_wr_q, own_wr_d;
  logic [WADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0]  wdata_q,  wdata_d;
  logic               read_q,   read_d;
  logic               write_q,  write_d;
  logic [NUM_RD:0]    grant_q,  grant_d;
  logic [NUM_RD-1:0]  rd_ack_q, rd_ack_d;
  logic               wr_ack_q, wr_ack_d;
  logic [DATA_W-1:0]  rdata_q,  rdata_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               err_q,    err_d;

  logic [NUM_RD-1:0]  eff_req;
  logic [PTR_W-1:0]   rr_start;
  logic               rd_found;
  logic [PTR_W-1:0]   rd_win;

  assign eff_req  = write_override ? '0 : (rd_req & rd_en_mask);
  assign rr_start = (RR_MODE != 0) ? ptr_q : '0;

  // Circular search from the start point; fixed priority is simply a start of 0.
  always_comb begin
    rd_found = 1'b0;
    rd_win   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!rd_found && eff_req[(int'(rr_start) + k) % NUM_RD]) begin
        rd_found = 1'b1;
        rd_win   = PTR_W'((int'(rr_start) + k) % NUM_RD);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    own_wr_d = own_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    read_d   = read_q;
    write_d  = write_q;
    grant_d  = grant_q;
    rd_ack_d = '0;
    wr_ack_d = 1'b0;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          own_wr_d        = 1'b1;
          addr_d          = wr_addr;
          wdata_d         = wr_data;
          write_d         = 1'b1;
          grant_d         = '0;
          grant_d[NUM_RD] = 1'b1;
          cnt_d           = '0;
          state_d         = S_ISSUE;
        end else if (rd_found) begin
          own_wr_d        = 1'b0;
          owner_d         = rd_win;
          addr_d          = rd_addr[int'(rd_win)*WADDR_W +: WADDR_W];
          wdata_d         = wr_data;
          read_d          = 1'b1;
          grant_d         = '0;
          grant_d[rd_win] = 1'b1;
          ptr_d           = PTR_W'((int'(rd_win) + 1) % NUM_RD);
          cnt_d           = '0;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ack_in_toavl) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          grant_d = '0;
          if (own_wr_q) begin
            wr_ack_d = 1'b1;
          end else begin
            rd_ack_d[owner_q] = 1'b1;
            rdata_d           = rddata_in_toavl;
          end
          state_d = S_RELEASE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          // Abort: no ack is given, the requester simply competes again from IDLE.
          read_d  = 1'b0;
          write_d = 1'b0;
          grant_d = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      own_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      grant_q  <= '0;
      rd_ack_q <= '0;
      wr_ack_q <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      own_wr_q <= own_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      read_q   <= read_d;
      write_q  <= write_d;
      grant_q  <= grant_d;
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign rd_ack           = rd_ack_q;
  assign rd_data          = rdata_q;
  assign wr_ack           = wr_ack_q;
  assign addr_out_toavl   = {addr_q, 1'b0};
  assign read_out_toavl   = read_q;
  assign write_out_toavl  = write_q;
  assign wrdata_out_toavl = wdata_q;
  assign grant            = grant_q;
  assign timeout_err      = err_q;

endmodule

// File: tb/tb_sdram_arbiter_nch.sv
// Bench for sdram_arbiter_nch: a round-robin and a fixed-priority instance share stimulus,
// each with its own bridge responder and a transaction-level reference model.
module tb_sdram_arbiter_nch;

  localparam int NRD = 2;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int TO  = 8;

  logic                clk50 = 1'b0;
  logic                reset_n;
  logic                write_override;
  logic [NRD-1:0]      rd_en_mask;
  logic [NRD-1:0]      rd_req;
  logic [NRD*AW-1:0]   rd_addr;
  logic                wr_req;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;

  logic                ackIn    [2];
  logic [DW-1:0]       rddataIn [2];
  logic [NRD-1:0]      rdAck    [2];
  logic [DW-1:0]       rdData   [2];
  logic                wrAck    [2];
  logic [AW:0]         addrOut  [2];
  logic                readOut  [2];
  logic                writeOut [2];
  logic [DW-1:0]       wrdataOut[2];
  logic [NRD:0]        grantOut [2];
  logic                tErr     [2];

  always #5 clk50 = ~clk50;

  // Instance 0 is round-robin, instance 1 is fixed priority.
  for (genvar g = 0; g < 2; g++) begin : gDut
    sdram_arbiter_nch #(
      .NUM_RD(NRD), .WADDR_W(AW), .DATA_W(DW), .RR_MODE(1 - g), .TIMEOUT(TO)
    ) u_dut (
      .clk50(clk50), .reset_n(reset_n), .write_override(write_override),
      .rd_en_mask(rd_en_mask), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ack(rdAck[g]), .rd_data(rdData[g]),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wrAck[g]),
      .addr_out_toavl(addrOut[g]), .read_out_toavl(readOut[g]),
      .write_out_toavl(writeOut[g]), .wrdata_out_toavl(wrdataOut[g]),
      .rddata_in_toavl(rddataIn[g]), .ack_in_toavl(ackIn[g]),
      .grant(grantOut[g]), .timeout_err(tErr[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Bridge behaviour: ack on command cycle ackDelay+1, never when ackDelay < 0.
  int          ackDelay = -1;
  logic        forceAck = 1'b0;
  int          cmdCnt   [2];
  logic [15:0] nextData [2];

  // Reference model: who owns the bus, whether the command is out or the ack is due.
  int          mOwner  [2];
  bit          mBusy   [2];
  bit          mAckDue [2];
  int          mWait   [2];
  int          mPtr    [2];
  logic [15:0] mRdData [2];
  bit          mErr    [2];
  logic [AW-1:0] mAddr [2];
  logic [15:0] mWdata  [2];

  // Observation log filled by the compare process.
  int          whoQ0[$];
  int          whoQ1[$];
  logic [15:0] datQ0[$];
  logic [15:0] datQ1[$];
  int          readHigh0 = 0;
  int          rdAckCnt0 = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ovr, input logic [1:0] mask, input logic [1:0] rreq,
                               input logic wreq, input logic [AW-1:0] waddr, input logic [15:0] wdata);
    write_override = ovr;
    rd_en_mask     = mask;
    rd_req         = rreq;
    wr_req         = wreq;
    wr_addr        = waddr;
    wr_data        = wdata;
  endtask

  task automatic modelReset(input int d);
    mOwner[d]  = 0;
    mBusy[d]   = 0;
    mAckDue[d] = 0;
    mWait[d]   = 0;
    mPtr[d]    = 0;
    mRdData[d] = '0;
    mErr[d]    = 0;
    mAddr[d]   = '0;
    mWdata[d]  = '0;
  endtask

  // One clock of the model: finish the in-flight command, pay out the ack, or pick a new owner.
  task automatic modelStep(input int d);
    logic [1:0] eff;
    int start;
    int pick;
    if (mBusy[d]) begin
      if (ackIn[d]) begin
        mBusy[d]   = 0;
        mAckDue[d] = 1;
        if (mOwner[d] < NRD) mRdData[d] = rddataIn[d];
      end else begin
        mWait[d]++;
        if (mWait[d] == TO) begin
          mBusy[d] = 0;
          mErr[d]  = 1;
        end
      end
    end else if (mAckDue[d]) begin
      mAckDue[d] = 0;
    end else begin
      eff = write_override ? 2'b00 : (rd_req & rd_en_mask);
      if (wr_req) begin
        mOwner[d] = NRD;
        mAddr[d]  = wr_addr;
        mWdata[d] = wr_data;
        mBusy[d]  = 1;
        mWait[d]  = 0;
      end else if (eff != 2'b00) begin
        start = (d == 0) ? mPtr[d] : 0;
        pick  = -1;
        for (int k = 0; k < NRD; k++)
          if (pick < 0 && eff[(start + k) % NRD]) pick = (start + k) % NRD;
        mOwner[d] = pick;
        mAddr[d]  = rd_addr[pick*AW +: AW];
        mBusy[d]  = 1;
        mWait[d]  = 0;
        mPtr[d]   = (pick + 1) % NRD;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk50 or negedge reset_n);
      for (int d = 0; d < 2; d++) begin
        if (!reset_n) modelReset(d);
        else modelStep(d);
      end
    end
  end

  // Compare, log and bridge-respond on every falling edge.
  initial begin
    for (int d = 0; d < 2; d++) begin
      ackIn[d]    = 1'b0;
      rddataIn[d] = 16'hDEAD;
      cmdCnt[d]   = 0;
      nextData[d] = 16'h1111;
    end
    forever begin
      @(negedge clk50);
      for (int d = 0; d < 2; d++) begin
        logic [2:0] expGrant;
        logic [1:0] expRdAck;
        expGrant = mBusy[d] ? 3'(1 << mOwner[d]) : 3'b000;
        expRdAck = (mAckDue[d] && mOwner[d] < NRD) ? 2'(1 << mOwner[d]) : 2'b00;
        checkOutput($sformatf("d%0d.grant", d), grantOut[d], expGrant);
        checkOutput($sformatf("d%0d.read", d), readOut[d], mBusy[d] && mOwner[d] < NRD);
        checkOutput($sformatf("d%0d.write", d), writeOut[d], mBusy[d] && mOwner[d] == NRD);
        checkOutput($sformatf("d%0d.rd_ack", d), rdAck[d], expRdAck);
        checkOutput($sformatf("d%0d.wr_ack", d), wrAck[d], mAckDue[d] && mOwner[d] == NRD);
        checkOutput($sformatf("d%0d.rd_data", d), rdData[d], mRdData[d]);
        checkOutput($sformatf("d%0d.timeout_err", d), tErr[d], mErr[d]);
        if (mBusy[d]) checkOutput($sformatf("d%0d.addr", d), addrOut[d], {mAddr[d], 1'b0});
        if (mBusy[d] && mOwner[d] == NRD)
          checkOutput($sformatf("d%0d.wrdata", d), wrdataOut[d], mWdata[d]);
      end
      if (rdAck[0] != 2'b00) begin
        whoQ0.push_back(rdAck[0][1] ? 1 : 0);
        datQ0.push_back(rdData[0]);
        rdAckCnt0++;
      end
      if (rdAck[1] != 2'b00) begin
        whoQ1.push_back(rdAck[1][1] ? 1 : 0);
        datQ1.push_back(rdData[1]);
      end
      if (readOut[0]) readHigh0++;
      for (int d = 0; d < 2; d++) begin
        if (readOut[d] || writeOut[d]) begin
          cmdCnt[d]++;
          ackIn[d]    = (ackDelay >= 0) && (cmdCnt[d] == ackDelay + 1);
          rddataIn[d] = 16'hDEAD;
          if (ackIn[d] && readOut[d]) begin
            rddataIn[d] = nextData[d];
            nextData[d] = nextData[d] + 16'h1111;
          end
        end else begin
          cmdCnt[d]   = 0;
          ackIn[d]    = forceAck;
          rddataIn[d] = 16'hDEAD;
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog expired before end of sequence");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int wHigh;
    int wAcks;
    int seen;
    int rHigh;
    bit found;
    int expWho0[4];
    logic [15:0] expDat[4];
    expWho0 = '{0, 1, 0, 1};
    expDat  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    reset_n = 1'b0;
    rd_addr = {25'h0000200, 25'h0000100};
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, '0, '0);
    modelReset(0);
    modelReset(1);
    repeat (3) @(negedge clk50);
    checkOutput("reset.grant", grantOut[0], 3'b000);
    checkOutput("reset.read", readOut[0], 1'b0);
    checkOutput("reset.rd_data", rdData[0], 16'h0000);
    checkOutput("reset.timeout_err", tErr[0], 1'b0);
    reset_n = 1'b1;
    @(negedge clk50);

    $display("[TB] single write, bridge acks 3 cycles after issue");
    ackDelay = 3;
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 25'h0000123, 16'hBEEF);
    @(negedge clk50);
    checkOutput("wr.first_write", writeOut[0], 1'b1);
    checkOutput("wr.addr", addrOut[0], 26'h0000246);
    checkOutput("wr.wrdata", wrdataOut[0], 16'hBEEF);
    checkOutput("wr.grant", grantOut[0], 3'b100);
    wHigh = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk50);
      if (wrAck[0]) found = 1;
      else if (writeOut[0]) wHigh++;
    end
    checkOutput("wr.ack_seen", found, 1'b1);
    wr_req = 1'b0;
    checkOutput("wr.cycles_high", wHigh, 4);
    wAcks = 1;
    repeat (4) begin
      @(negedge clk50);
      if (wrAck[0]) wAcks++;
    end
    checkOutput("wr.ack_pulses", wAcks, 1);

    $display("[TB] both readers requesting, ack 1 cycle after issue");
    ackDelay = 1;
    whoQ0.delete(); whoQ1.delete(); datQ0.delete(); datQ1.delete();
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b0, '0, '0);
    seen = 0;
    for (int i = 0; i < 60 && seen < 4; i++) begin
      @(negedge clk50);
      if (rdAck[0] != 2'b00) seen++;
    end
    rd_req = 2'b00;
    repeat (4) @(negedge clk50);
    checkOutput("rr.ack_count", whoQ0.size(), 4);
    checkOutput("fp.ack_count", whoQ1.size(), 4);
    for (int i = 0; i < 4 && i < whoQ0.size(); i++) begin
      checkOutput($sformatf("rr.who%0d", i), whoQ0[i], expWho0[i]);
      checkOutput($sformatf("rr.data%0d", i), datQ0[i], expDat[i]);
    end
    for (int i = 0; i < 4 && i < whoQ1.size(); i++) begin
      checkOutput($sformatf("fp.who%0d", i), whoQ1[i], 0);
      checkOutput($sformatf("fp.data%0d", i), datQ1[i], expDat[i]);
    end

    $display("[TB] write override blocks readers; stray bridge ack in idle");
    readHigh0 = 0;
    rdAckCnt0 = 0;
    applyStimulus(1'b1, 2'b11, 2'b11, 1'b0, '0, '0);
    repeat (3) @(negedge clk50);
    forceAck = 1'b1;
    repeat (2) @(negedge clk50);
    forceAck = 1'b0;
    repeat (2) @(negedge clk50);
    applyStimulus(1'b1, 2'b11, 2'b11, 1'b1, 25'h0000055, 16'h1234);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk50);
      if (wrAck[0]) found = 1;
    end
    checkOutput("ovr.wr_ack_seen", found, 1'b1);
    wr_req = 1'b0;
    repeat (3) @(negedge clk50);
    checkOutput("ovr.no_reads", readHigh0, 0);
    checkOutput("ovr.no_rd_ack", rdAckCnt0, 0);

    $display("[TB] mask leaves only reader 0");
    whoQ0.delete(); whoQ1.delete(); datQ0.delete(); datQ1.delete();
    applyStimulus(1'b0, 2'b01, 2'b11, 1'b0, '0, '0);
    seen = 0;
    for (int i = 0; i < 60 && seen < 3; i++) begin
      @(negedge clk50);
      if (rdAck[0] != 2'b00) seen++;
    end
    rd_req = 2'b00;
    repeat (3) @(negedge clk50);
    checkOutput("mask.ack_count", whoQ0.size(), 3);
    for (int i = 0; i < whoQ0.size(); i++)
      checkOutput($sformatf("mask.who%0d", i), whoQ0[i], 0);

    $display("[TB] bridge never acks, timeout aborts");
    ackDelay  = -1;
    rdAckCnt0 = 0;
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b0, '0, '0);
    @(negedge clk50);
    checkOutput("to.first_grant", grantOut[0], 3'b010);
    rHigh = readOut[0] ? 1 : 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk50);
      if (!readOut[0]) found = 1;
      else rHigh++;
    end
    checkOutput("to.dropped", found, 1'b1);
    checkOutput("to.read_cycles", rHigh, TO);
    checkOutput("to.err_set", tErr[0], 1'b1);
    @(negedge clk50);
    checkOutput("to.next_grant", grantOut[0], 3'b001);
    checkOutput("to.no_rd_ack", rdAckCnt0, 0);

    $display("[TB] reset asserted mid-transaction");
    @(posedge clk50);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst.read_drop", readOut[0], 1'b0);
    checkOutput("rst.grant_drop", grantOut[0], 3'b000);
    checkOutput("rst.err_clear", tErr[0], 1'b0);
    ackDelay = 1;
    @(negedge clk50);
    @(negedge clk50);
    reset_n = 1'b1;
    @(negedge clk50);
    checkOutput("rst.regrant_r0", grantOut[0], 3'b001);
    checkOutput("rst.regrant_read", readOut[0], 1'b1);
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk50);
      if (rdAck[0] != 2'b00) seen++;
    end
    checkOutput("rst.acks_after", seen, 2);
    rd_req = 2'b00;
    repeat (4) @(negedge clk50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter_nch.md
Name: sdram_arbiter_nch

Overview:
- Parametrised successor to the current fixed two-reader/one-writer SDRAM bus arbiter.
- Multiplexes NUM_RD read requesters (video, audio, future peripherals) and one writer (SD-card loader) onto the single Avalon bridge master in front of the SDRAM controller.
- Supports fixed-priority or round-robin reader arbitration, a per-reader enable mask, write override, word-to-byte address conversion, and an ack timeout with a sticky error flag.

Parameters:
- NUM_RD, 2, number of read requesters (1..8).
- WADDR_W, 25, requester word-address width; bus address width is WADDR_W+1.
- DATA_W, 16, data width.
- RR_MODE, 1, 1 = round-robin among readers, 0 = fixed priority (lowest index wins).
- TIMEOUT, 1023, maximum cycles to wait for ack_in_toavl before abort; 0 disables the timeout.

Ports:
- clk50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- write_override  in  1  1 = only the writer may be granted.
- rd_en_mask  in  NUM_RD  per-reader enable; a 0 masks that reader's request.
- rd_req  in  NUM_RD  read request, level, held until acked.
- rd_addr  in  NUM_RD*WADDR_W  packed word addresses; reader i uses bits [i*WADDR_W +: WADDR_W].
- rd_ack  out  NUM_RD  one-cycle ack to the granted reader.
- rd_data  out  DATA_W  registered read data, broadcast to all readers, valid when rd_ack pulses.
- wr_req  in  1  write request, level.
- wr_addr  in  WADDR_W  write word address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  one-cycle ack to the writer.
- addr_out_toavl  out  WADDR_W+1  byte address = {word_addr, 1'b0}.
- read_out_toavl  out  1  Avalon read.
- write_out_toavl  out  1  Avalon write.
- wrdata_out_toavl  out  DATA_W  Avalon write data.
- rddata_in_toavl  in  DATA_W  Avalon read data.
- ack_in_toavl  in  1  Avalon ack, one cycle.
- grant  out  NUM_RD+1  one-hot current owner; bit NUM_RD = writer; all zeros when idle.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer points at reader 0.
  - In-flight command is dropped immediately.
- States: IDLE -> ISSUE -> RELEASE -> IDLE. All outputs are registered.
- IDLE:
  - Effective reader requests = rd_req & rd_en_mask, forced to 0 when write_override=1.
  - Writer request has absolute priority over readers.
  - If any request is present, latch the winner, its address and its data; set grant; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Hold read_out_toavl or write_out_toavl (exactly one), plus addr_out_toavl and wrdata_out_toavl, stable every cycle until ack_in_toavl=1.
  - On ack: capture rddata_in_toavl (reads) and go to RELEASE.
- RELEASE (one cycle):
  - Command deasserted.
  - Owner's rd_ack[i] or wr_ack = 1.
  - rd_data holds the captured word; it is held until the next read capture.
  - grant cleared; next state IDLE.
- Latency: request seen in IDLE at cycle k -> command asserted at k+1. Ack_in at cycle m -> requester ack at m+1 -> earliest next command at m+3.
- Round-robin:
  - After a reader grant, the pointer moves to (winner+1) mod NUM_RD.
  - Search starts at the pointer.
  - Writer grants do not move the pointer.
- Changes to write_override or rd_en_mask during ISSUE do not abort the in-flight transaction; they apply at the next IDLE.
- Requester drops req after grant: the transaction still completes and the ack is still pulsed.
- Requester addr/data changes after grant are ignored (latched copy is used).
- Timeout (TIMEOUT>0):
  - A counter is cleared on entering ISSUE.
  - When it reaches TIMEOUT with no ack: deassert the command, set timeout_err, do not pulse an ack, go to IDLE.
  - The pointer still advances.
  - timeout_err clears only on reset.
- ack_in_toavl outside ISSUE is ignored.

Test Plan:
- Reset, then wr_req=1 with wr_addr=0x0000123, wr_data=0xBEEF; bridge acks 3 cycles later -> write_out_toavl high for 4 cycles with addr_out_toavl=0x0000246 and wrdata=0xBEEF; wr_ack one pulse; grant=3'b100 during the transaction.
- NUM_RD=2, RR_MODE=1, both readers requesting continuously, ack 1 cycle after issue -> grants alternate 0,1,0,1; each rd_ack pulse carries the matching rddata_in (0x1111, 0x2222, ...).
- RR_MODE=0, same stimulus -> reader 0 is granted every transaction; reader 1 is starved.
- write_override=1 with rd_req=2'b11 and wr_req=0 -> no command issued; raise wr_req -> only the write executes; rd_en_mask=2'b01 with override=0 -> only reader 0 is served.
- TIMEOUT=8, bridge never acks -> read deasserts after 8 cycles; timeout_err=1 and stays set; no rd_ack; the next reader is granted.
- Assert reset_n=0 mid-ISSUE -> read_out_toavl and grant drop to 0 asynchronously; after release, the pending request is re-issued starting from reader 0.
